// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits MSB first, optional even parity, 1 or 2 stop bits.
// One byte is accepted per valid/ready handshake; the serial line idles high.
module uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       tx_clk,
    input  logic       tx_rst,
    input  logic       tx_en,
    input  logic [7:0] tx_i_data,
    input  logic       tx_i_data_valid,
    output logic       tx_o_ready,
    output logic       o_tx,
    output logic       tx_o_busy,
    output logic       tx_o_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             accept;
    logic             bit_end;

    assign tx_o_ready = (state_q == IDLE) && tx_en && !tx_rst;
    assign accept     = tx_i_data_valid && tx_o_ready;
    assign bit_end    = (cnt_q == CNT_LAST);
    assign o_tx       = tx_q;
    assign tx_o_busy  = (state_q != IDLE);
    assign tx_o_done  = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shreg_d = tx_i_data;
                    par_d   = ^tx_i_data;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd7;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd0) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        idx_d   = STOP_LAST;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    idx_d   = STOP_LAST;
                end
            end
            STOP: begin
                // idx counts the remaining stop bits so two stop bits reuse the bit timer
                if (bit_end) begin
                    if (idx_q == 3'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so it changes with the state
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[idx_d];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at 16 clocks per bit, even parity, one stop bit.
// Accepts push expected frames; a line monitor decodes o_tx and a done monitor checks latency.
module tb_uart_tx;

    localparam int CPB       = 16;
    localparam int FRAME_CYC = 11 * CPB;

    localparam logic [10:0] F_CE = 11'b0_11001110_1_1;
    localparam logic [10:0] F_AA = 11'b0_10101010_0_1;
    localparam logic [10:0] F_3C = 11'b0_00111100_0_1;
    localparam logic [10:0] F_FF = 11'b0_11111111_0_1;
    localparam logic [10:0] F_55 = 11'b0_01010101_0_1;
    localparam logic [10:0] F_81 = 11'b0_10000001_0_1;

    logic       tx_clk = 1'b0;
    logic       tx_rst = 1'b1;
    logic       tx_en = 1'b1;
    logic [7:0] tx_i_data = 8'h00;
    logic       tx_i_data_valid = 1'b1;
    logic       tx_o_ready;
    logic       o_tx;
    logic       tx_o_busy;
    logic       tx_o_done;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (1),
        .STOP_BITS   (1)
    ) dut (
        .tx_clk         (tx_clk),
        .tx_rst         (tx_rst),
        .tx_en          (tx_en),
        .tx_i_data      (tx_i_data),
        .tx_i_data_valid(tx_i_data_valid),
        .tx_o_ready     (tx_o_ready),
        .o_tx           (o_tx),
        .tx_o_busy      (tx_o_busy),
        .tx_o_done      (tx_o_done)
    );

    always #5 tx_clk = ~tx_clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [10:0] cur_exp = F_CE;
    logic [10:0] exp_q[$];
    int          acc_q[$];
    int          acc_hist[$];

    logic        mon_active = 1'b0;
    int          mon_cnt = 0;
    logic [10:0] cap = '0;

    always @(posedge tx_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Accept happens on the next rising edge; record it and the frame it should produce
    always @(negedge tx_clk) begin
        if (!tx_rst && tx_i_data_valid && tx_o_ready) begin
            exp_q.push_back(cur_exp);
            acc_q.push_back(cyc + 1);
            acc_hist.push_back(cyc + 1);
        end
    end

    always @(negedge tx_clk) begin
        if (tx_o_done) begin
            if (acc_q.size() == 0) begin
                chk("done_spurious", 32'd1, 32'd0);
            end else begin
                chk("done_latency", 32'(cyc - acc_q[0]), 32'(FRAME_CYC));
                void'(acc_q.pop_front());
            end
        end
    end

    // Line monitor: detect start edge, sample each bit at its centre
    always @(negedge tx_clk) begin
        if (tx_rst) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (o_tx == 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 1;
            end
        end else begin
            if (mon_cnt % CPB == CPB / 2) cap <= {cap[9:0], o_tx};
            if (mon_cnt == 10 * CPB + CPB / 2) begin
                mon_active <= 1'b0;
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("frame", 32'({cap[9:0], o_tx}), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
            mon_cnt <= mon_cnt + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge tx_clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (acc_hist.size() >= n) return;
        end
        chk("accept_timeout", 32'(acc_hist.size()), 32'(n));
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (exp_q.size() == 0 && acc_q.size() == 0 && !tx_o_busy) return;
        end
        chk("idle_timeout", 32'(exp_q.size() + acc_q.size()), 32'd0);
    endtask

    task automatic send(input logic [7:0] b, input logic [10:0] f);
        int n0;
        n0 = acc_hist.size();
        tx_i_data       = b;
        cur_exp         = f;
        tx_i_data_valid = 1'b1;
        wait_acc(n0 + 1, 2000);
        tx_i_data_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;

        // Reset held with valid and enable high
        step(3);
        chk("rst_otx", o_tx, 1);
        chk("rst_ready", tx_o_ready, 0);
        chk("rst_busy", tx_o_busy, 0);
        chk("rst_done", tx_o_done, 0);
        tx_i_data_valid = 1'b0;
        tx_rst = 1'b0;
        #1;
        chk("post_rst_ready", tx_o_ready, 1);
        chk("post_rst_otx", o_tx, 1);
        step(5);
        chk("idle_otx", o_tx, 1);
        chk("idle_busy", tx_o_busy, 0);

        // Single frames
        send(8'hCE, F_CE);
        chk("start_otx", o_tx, 0);
        chk("start_busy", tx_o_busy, 1);
        chk("start_ready", tx_o_ready, 0);
        wait_idle(400);
        send(8'hAA, F_AA);
        wait_idle(400);

        // Back-to-back with valid held; data changes right after the first accept
        n0 = acc_hist.size();
        tx_i_data       = 8'hCE;
        cur_exp         = F_CE;
        tx_i_data_valid = 1'b1;
        wait_acc(n0 + 1, 100);
        tx_i_data = 8'h3C;
        cur_exp   = F_3C;
        wait_acc(n0 + 2, 400);
        tx_i_data_valid = 1'b0;
        if (acc_hist.size() >= n0 + 2) begin
            chk("b2b_gap", 32'(acc_hist[n0+1] - acc_hist[n0]), 32'(FRAME_CYC + 1));
        end
        wait_idle(400);

        // Enable dropped and data changed mid-frame
        send(8'hCE, F_CE);
        step(40);
        tx_en           = 1'b0;
        tx_i_data       = 8'hFF;
        cur_exp         = F_FF;
        tx_i_data_valid = 1'b1;
        n0 = acc_hist.size();
        wait_idle(400);
        step(30);
        chk("en0_ready", tx_o_ready, 0);
        chk("en0_no_accept", 32'(acc_hist.size()), 32'(n0));
        chk("en0_otx", o_tx, 1);
        tx_en = 1'b1;
        wait_acc(n0 + 1, 10);
        tx_i_data_valid = 1'b0;
        wait_idle(400);

        // Reset during data bit 3 (0x55 has a 0 there)
        send(8'h55, F_55);
        step(87);
        chk("pre_rst_otx", o_tx, 0);
        tx_rst = 1'b1;
        #1;
        chk("midrst_otx", o_tx, 1);
        chk("midrst_busy", tx_o_busy, 0);
        chk("midrst_ready", tx_o_ready, 0);
        exp_q.delete();
        acc_q.delete();
        step(2);
        tx_rst = 1'b0;
        #1;
        chk("rel_ready", tx_o_ready, 1);
        chk("rel_otx", o_tx, 1);
        step(200);
        send(8'h81, F_81);
        wait_idle(400);
        step(20);
        chk("queues_empty", 32'(exp_q.size() + acc_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
